// File: rtl/uart_rx_core.sv
// 16x-oversampling 8N1 UART receiver with majority-vote bit sampling and
// sticky avail/framing/overrun flags cleared by a rising edge on rx_ack.
module uart_rx_core #(
    parameter int unsigned freq_hz = 26000000,
    parameter int unsigned baud    = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int unsigned DIV_RAW = (freq_hz + 8 * baud) / (16 * baud);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t           state, state_d;
    logic [1:0]       sync_q;
    logic             rxs;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [3:0]       sc, sc_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       shift, shift_d;
    logic [2:0]       smp, smp_d;
    logic             maj;
    logic             ack_q, ack_rise;
    logic [7:0]       data_d;
    logic             avail_d, err_d, ovr_d;

    assign rxs      = sync_q[1];
    assign tick     = (tick_cnt == CNT_W'(DIV - 1));
    assign ack_rise = rx_ack & ~ack_q;
    assign rx_busy  = (state != IDLE);

    // Third vote comes straight from the line when evaluated at sc==9 (STOP).
    always_comb begin
        logic s9;
        s9  = (sc == 4'd9) ? rxs : smp[2];
        maj = (smp[0] & smp[1]) | (smp[0] & s9) | (smp[1] & s9);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        sc_d    = sc;
        idx_d   = idx;
        shift_d = shift;
        smp_d   = smp;
        data_d  = rx_data;
        avail_d = rx_avail;
        err_d   = rx_error;
        ovr_d   = rx_overrun;

        if (ack_rise) begin
            avail_d = 1'b0;
            err_d   = 1'b0;
            ovr_d   = 1'b0;
        end

        if (tick) begin
            if (sc == 4'd7) smp_d[0] = rxs;
            if (sc == 4'd8) smp_d[1] = rxs;
            if (sc == 4'd9) smp_d[2] = rxs;
        end

        case (state)
            IDLE: begin
                sc_d = 4'd0;
                // The detect tick itself counts as sample slot 0.
                if (tick && !rxs) begin
                    state_d = START;
                    sc_d    = 4'd1;
                end
            end
            START: begin
                if (tick) begin
                    sc_d = sc + 4'd1;
                    if (sc == 4'd15) begin
                        if (maj) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            idx_d   = 3'd0;
                        end
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sc_d = sc + 4'd1;
                    if (sc == 4'd15) begin
                        shift_d = {maj, shift[7:1]};
                        idx_d   = idx + 3'd1;
                        if (idx == 3'd7) state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    sc_d = sc + 4'd1;
                    if (sc == 4'd9) begin
                        if (maj) begin
                            data_d  = shift;
                            ovr_d   = ovr_d | avail_d;
                            avail_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = BRK;
                        end
                    end
                end
            end
            BRK: begin
                sc_d = 4'd0;
                if (rxs) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                sc_d    = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= 2'b11;
            tick_cnt   <= '0;
            sc         <= 4'd0;
            idx        <= 3'd0;
            shift      <= 8'd0;
            smp        <= 3'd0;
            ack_q      <= 1'b0;
            rx_data    <= 8'd0;
            rx_avail   <= 1'b0;
            rx_error   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], uart_rxd};
            tick_cnt   <= tick ? '0 : tick_cnt + CNT_W'(1);
            sc         <= sc_d;
            idx        <= idx_d;
            shift      <= shift_d;
            smp        <= smp_d;
            ack_q      <= rx_ack;
            rx_data    <= data_d;
            rx_avail   <= avail_d;
            rx_error   <= err_d;
            rx_overrun <= ovr_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame table, timed corner sequences, randomized
// frames against a flag-level model, and a default-parameter baud check.
module tb_uart_rx_core;

    localparam int unsigned BIT2 = 4514;   // 225.69 clk2 periods of 20 units

    logic       clk = 1'b0, clk2 = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rxd = 1'b1, rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_avail, rx_error, rx_overrun, rx_busy;
    logic       rxd2 = 1'b1, ack2 = 1'b0;
    logic [7:0] data2;
    logic       avail2, err2, ovr2, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5  clk  = ~clk;
    always #10 clk2 = ~clk2;

    uart_rx_core #(.freq_hz(1600000), .baud(100000)) dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error),
        .rx_overrun(rx_overrun), .rx_busy(rx_busy)
    );

    uart_rx_core dut2 (
        .clk(clk2), .rst(rst), .uart_rxd(rxd2), .rx_ack(ack2),
        .rx_data(data2), .rx_avail(avail2), .rx_error(err2),
        .rx_overrun(ovr2), .rx_busy(busy2)
    );

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ack_before;
        logic [7:0] e_data;
        logic       e_avail;
        logic       e_err;
        logic       e_ovr;
    } vec_t;

    // Flag-level reference model
    logic [7:0] m_data;
    logic       m_avail, m_err, m_ovr;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; leaves the line at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            wait_clk(16);
        end
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        wait_clk(2);
        rx_ack = 1'b0;
        wait_clk(2);
    endtask

    task automatic frame_and_settle(input logic [7:0] d, input logic stop);
        send_frame(d, stop);
        if (!stop) begin
            wait_clk(24);
            uart_rxd = 1'b1;
            wait_clk(6);
        end else begin
            wait_clk(4);
        end
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (stop) begin
            m_ovr   = m_ovr | m_avail;
            m_avail = 1'b1;
            m_data  = d;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input logic a,
                             input logic e, input logic o);
        chk({tag, " data"}, rx_data, d);
        chk({tag, " avail"}, rx_avail, a);
        chk({tag, " error"}, rx_error, e);
        chk({tag, " overrun"}, rx_overrun, o);
    endtask

    task automatic send_frame2(input logic [7:0] d);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd2 = bits[i];
            #(BIT2);
        end
    endtask

    initial begin
        vec_t tbl[7];
        int   cnt;
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h11, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

        wait_clk(3);
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset busy", rx_busy, 1'b0);
        rst = 1'b1;
        wait_clk(10);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].ack_before) ack_pulse();
            frame_and_settle(tbl[i].d, tbl[i].stop);
            check_all($sformatf("tbl%0d", i), tbl[i].e_data, tbl[i].e_avail,
                      tbl[i].e_err, tbl[i].e_ovr);
            chk($sformatf("tbl%0d busy", i), rx_busy, 1'b0);
        end

        // Latency from falling start edge to rx_avail, then single-clock ack
        ack_pulse();
        cnt = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!rx_avail && cnt < 300) begin
                    @(negedge clk);
                    cnt++;
                    if (cnt == 80) chk("busy mid-frame", rx_busy, 1'b1);
                end
            end
        join
        chk("latency in 155..157", 8'((cnt >= 155 && cnt <= 157) ? 1 : 0), 8'd1);
        check_all("lat frame", 8'hA5, 1'b1, 1'b0, 1'b0);
        rx_ack = 1'b1;
        @(negedge clk);
        chk("ack next clk", rx_avail, 1'b0);
        rx_ack = 1'b0;
        wait_clk(4);

        // Glitch shorter than half a bit is a false start
        uart_rxd = 1'b0;
        wait_clk(4);
        uart_rxd = 1'b1;
        wait_clk(16);
        chk("false start busy", rx_busy, 1'b0);
        check_all("false start", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Framing error holds busy until the line recovers
        send_frame(8'h3C, 1'b0);
        wait_clk(24);
        check_all("framing", 8'hA5, 1'b0, 1'b1, 1'b0);
        chk("framing busy low line", rx_busy, 1'b1);
        uart_rxd = 1'b1;
        wait_clk(6);
        chk("framing busy released", rx_busy, 1'b0);

        // Held-high ack clears only once
        rx_ack = 1'b1;
        wait_clk(2);
        frame_and_settle(8'h33, 1'b1);
        check_all("held ack", 8'h33, 1'b1, 1'b0, 1'b0);
        rx_ack = 1'b0;
        wait_clk(2);

        // Ack rise on the completion clock: completion wins, overrun stays clear
        fork
            send_frame(8'h6B, 1'b1);
            begin
                wait_clk(155);
                rx_ack = 1'b1;
            end
        join
        wait_clk(4);
        check_all("ack+complete", 8'h6B, 1'b1, 1'b0, 1'b0);
        rx_ack = 1'b0;
        wait_clk(2);

        // Reset during data bit 3
        uart_rxd = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 3; i++) begin
            uart_rxd = (i == 1);
            wait_clk(16);
        end
        uart_rxd = 1'b0;
        wait_clk(8);
        rst = 1'b0;
        #1;
        check_all("async rst", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("async rst busy", rx_busy, 1'b0);
        @(negedge clk);
        uart_rxd = 1'b1;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(20);
        frame_and_settle(8'h5A, 1'b1);
        check_all("post rst", 8'h5A, 1'b1, 1'b0, 1'b0);

        // Randomized frames against the model
        m_data = 8'h5A; m_avail = 1'b1; m_err = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic       stop;
            d    = 8'($urandom);
            stop = ($urandom_range(4) != 0);
            if ($urandom_range(2) == 0) begin
                ack_pulse();
                m_avail = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
            end
            frame_and_settle(d, stop);
            model_frame(d, stop);
            check_all($sformatf("rand%0d", i), m_data, m_avail, m_err, m_ovr);
            wait_clk(int'($urandom_range(30, 2)));
        end

        // Default parameters at the true line rate
        wait_clk(20);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            d = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h55;
            send_frame2(d);
            #(BIT2);
            chk($sformatf("div14 %0d data", i), data2, d);
            chk($sformatf("div14 %0d avail", i), avail2, 1'b1);
            chk($sformatf("div14 %0d error", i), err2, 1'b0);
            chk($sformatf("div14 %0d busy", i), busy2, 1'b0);
            @(negedge clk2);
            ack2 = 1'b1;
            repeat (2) @(negedge clk2);
            ack2 = 1'b0;
            repeat (2) @(negedge clk2);
            chk($sformatf("div14 %0d ack", i), avail2, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
